// File: rtl/dmem_copy_engine.sv
// Block-move helper for the 32-word data memory: copies len words from src to dst,
// one read cycle and one write cycle per word, accumulating a checksum of the words read.
module dmem_copy_engine #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [AW-1:0] src_i,
  input  logic [AW-1:0] dst_i,
  input  logic [AW:0]   len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] checksum_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  // state | meaning
  // IDLE  | waiting for start; memory port parked, mem_we low
  // RD    | mem_addr = src + idx, capturing the read word
  // WR    | mem_addr = dst + idx, writing the captured word
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] buf_q, buf_d;
  logic [DW-1:0] cs_q, cs_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          last_word;

  assign last_word = ({1'b0, idx_q} == (len_q - LEN_ONE));

  // Next-state decode. The memory port registers are loaded one edge ahead,
  // so every mem_* output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;

    case (state_q)
      S_IDLE: begin
        we_d = 1'b0;
        // A start landing in the done cycle is dropped; the next cycle may start.
        if (start_i && !done_q) begin
          src_d = src_i;
          dst_d = dst_i;
          len_d = len_i;
          cs_d  = '0;
          idx_d = '0;
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            addr_d  = src_i;
            state_d = S_RD;
          end
        end
      end

      S_RD: begin
        buf_d   = mem_rdata_i;
        cs_d    = cs_q + mem_rdata_i;
        addr_d  = dst_q + idx_q;
        we_d    = 1'b1;
        state_d = S_WR;
      end

      S_WR: begin
        we_d = 1'b0;
        if (last_word) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          addr_d  = src_q + idx_q + IDX_ONE;
          state_d = S_RD;
        end
      end

      default: begin
        busy_d  = 1'b0;
        we_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      cs_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign checksum_o  = cs_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = buf_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Bench for dmem_copy_engine: behavioural 32-word memory, a table of copy vectors,
// and hand sequences for reset-abort and start in/after the done cycle.
module tb_dmem_copy_engine;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] src, dst;
  logic [AW:0]   len;
  logic          busy, done, mem_we;
  logic [DW-1:0] checksum, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  dmem_copy_engine #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .src_i(src), .dst_i(dst), .len_i(len),
    .busy_o(busy), .done_o(done), .checksum_o(checksum),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem    [32];
  logic [31:0] pl_img [32];
  logic        pl_req = 1'b0;

  always @(posedge clk) begin
    if (pl_req) begin
      for (int i = 0; i < 32; i++) mem[i] <= pl_img[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] std_word(input int i);
    case (i)
      0: return 32'd4;   1: return 32'd5;   2: return 32'd6;   3: return 32'd7;
      4: return 32'd8;   5: return 32'd9;   6: return 32'hFFFF_FFEF;
      7: return 32'd1;   8: return 32'd2;   9: return 32'd3;
      10: return 32'd4;  11: return 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  task automatic preload(input int sel);
    for (int i = 0; i < 32; i++) pl_img[i] = std_word(i);
    if (sel == 2) begin
      pl_img[30] = 32'd10;
      pl_img[31] = 32'd11;
    end
    @(negedge clk); pl_req = 1'b1;
    @(negedge clk); pl_req = 1'b0;
  endtask

  // Sample n=0 is the negedge right after the accepting edge.
  task automatic run_copy(input logic [4:0] s, input logic [4:0] d, input logic [5:0] l,
                          input int poke, output int done_cnt, output int done_n,
                          output int we_cnt, output int busy_cnt, output int ovl);
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0; done_n = -1; we_cnt = 0; busy_cnt = 0; ovl = 0;
    for (int n = 0; n < 2 * int'(l) + 6; n++) begin
      if (n > 0) @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (mem_we) we_cnt++;
      if (busy) busy_cnt++;
      if (busy && done) ovl++;
      start = (n == poke);
      src   = (n == poke) ? s + 5'd7 : s;
    end
    start = 1'b0;
  endtask

  typedef struct packed {
    int          pre;
    logic [4:0]  s;
    logic [4:0]  d;
    logic [5:0]  l;
    int          poke;
    logic [31:0] cs;
    int          base;
    int          nchk;
    logic [4:0][31:0] ev;
  } vec_t;

  vec_t vt [9];

  task automatic setv(input int i, input int pre, input logic [4:0] s, input logic [4:0] d,
                      input logic [5:0] l, input int poke, input logic [31:0] cs,
                      input int base, input int nchk, input logic [31:0] e0,
                      input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3,
                      input logic [31:0] e4);
    vt[i].pre = pre;  vt[i].s = s;  vt[i].d = d;  vt[i].l = l;  vt[i].poke = poke;
    vt[i].cs = cs;    vt[i].base = base;  vt[i].nchk = nchk;
    vt[i].ev[0] = e0; vt[i].ev[1] = e1; vt[i].ev[2] = e2; vt[i].ev[3] = e3; vt[i].ev[4] = e4;
  endtask

  initial begin
    int dc, dn, wc, bc, ov, seen;
    logic [4:0] ix;

    // pre: 0 keep memory, 1 standard preload, 2 standard plus mem[30]=10, mem[31]=11
    setv(0, 1,  0, 12,  4, -1, 32'd22,        12, 5, 4, 5, 6, 7, 0);
    setv(1, 0,  4, 20,  3, -1, 32'd0,         20, 4, 8, 9, 32'hFFFF_FFEF, 0, 0);
    setv(2, 2, 30, 16,  4, -1, 32'd30,        16, 5, 10, 11, 4, 5, 0);
    setv(3, 1,  0,  1,  3, -1, 32'd12,         0, 5, 4, 4, 4, 4, 8);
    setv(4, 0,  5,  7,  0, -1, 32'd0,          4, 5, 8, 9, 32'hFFFF_FFEF, 1, 2);
    setv(5, 1,  0, 12,  4,  3, 32'd22,        12, 5, 4, 5, 6, 7, 0);
    setv(6, 0,  2,  2,  2, -1, 32'd13,         0, 5, 4, 5, 6, 7, 8);
    setv(7, 1,  0,  0, 32, -1, 32'd36,         8, 5, 2, 3, 4, 4, 0);
    setv(8, 0,  0, 30,  3, -1, 32'd15,        30, 3, 4, 5, 6, 0, 0);

    reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 9; v++) begin
      if (vt[v].pre != 0) preload(vt[v].pre);
      run_copy(vt[v].s, vt[v].d, vt[v].l, vt[v].poke, dc, dn, wc, bc, ov);
      $display("vector %0d: src=%0d dst=%0d len=%0d", v, vt[v].s, vt[v].d, vt[v].l);
      chk("done_count", 32'(dc), 32'd1);
      chk("done_cycle", 32'(dn), (vt[v].l == 0) ? 32'd0 : 32'(2 * int'(vt[v].l)));
      chk("write_count", 32'(wc), 32'(vt[v].l));
      chk("busy_cycles", 32'(bc), 32'(2 * int'(vt[v].l)));
      chk("busy_done_overlap", 32'(ov), 32'd0);
      chk("checksum", checksum, vt[v].cs);
      for (int k = 0; k < vt[v].nchk; k++) begin
        ix = 5'((vt[v].base + k) % 32);
        chk($sformatf("mem[%0d]", ix), mem[ix], vt[v].ev[k]);
      end
    end

    // Reset during the RD that follows the second write of a len=4 copy.
    preload(1);
    @(negedge clk); src = 5'd0; dst = 5'd12; len = 6'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_checksum", checksum, 32'd0);
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done || mem_we) seen++;
    end
    chk("abort_no_done_no_write", 32'(seen), 32'd0);
    chk("abort_mem12", mem[12], 32'd4);
    chk("abort_mem13", mem[13], 32'd5);
    chk("abort_mem14", mem[14], 32'd0);
    chk("abort_mem15", mem[15], 32'd0);

    // Start during the done cycle is dropped; start in the next cycle is taken.
    preload(1);
    @(negedge clk); src = 5'd0; dst = 5'd12; len = 6'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    chk("seq_done_seen", 32'(seen), 32'd1);
    src = 5'd1; dst = 5'd20; len = 6'd1; start = 1'b1;
    @(negedge clk);
    chk("start_in_done_ignored", 32'(busy), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("start_after_done_taken", 32'(busy), 32'd1);
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("seq2_done_seen", 32'(seen), 32'd1);
    chk("seq_mem12", mem[12], 32'd4);
    chk("seq_mem13", mem[13], 32'd5);
    chk("seq_mem20", mem[20], 32'd5);
    chk("seq_checksum", checksum, 32'd5);
    repeat (3) @(negedge clk);
    chk("checksum_stable", checksum, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
